// File: rtl/stopwatch_disp_mux_if.sv
// Bus between the stopwatch counter and the display mux: captured BCD
// digits, load strobe and wrap pulse in; pin-facing display signals out.
interface stopwatch_disp_mux_if;
    logic [15:0] bcd_in;
    logic        load;
    logic        max_tick;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        scan_done;

    // Stopwatch side: drives digits and strobes, observes the display pins
    modport master (output bcd_in, load, max_tick, input an, seg, dp, scan_done);
    // Display mux side
    modport slave  (input bcd_in, load, max_tick, output an, seg, dp, scan_done);
endinterface

// File: rtl/stopwatch_disp_mux.sv
// Four-digit common-anode seven-segment scan mux for the stopwatch.
// Captures BCD digits on load, scans them REFRESH_DIV cycles per digit, and
// blinks the anodes after an overflow until reset. All outputs registered.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros of d3/d2).
module stopwatch_disp_mux #(
    parameter int REFRESH_DIV = 4,
    parameter int BLINK_LOG2  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_disp_mux_if.slave  bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]         pcnt;
    logic [1:0]            idx;
    logic [BLINK_LOG2:0]   frame_cnt;
    logic [15:0]           shadow;
    logic                  ovf;
    logic                  slot_end;
    logic                  wrap;

    logic [3:0]            an_q, an_n;
    logic [6:0]            seg_q, seg_n;
    logic                  dp_q, dp_n;
    logic                  scan_done_q;
    logic [3:0]            digit;
    logic                  blank_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111; // invalid BCD shows a dash
        endcase
        return s;
    endfunction

    assign slot_end = (pcnt == PMAX);
    assign wrap     = slot_end && (idx == 2'd3);

    // Prescaler, digit index, scan-frame counter and wrap pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt        <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            scan_done_q <= 1'b0;
        end else begin
            pcnt        <= slot_end ? '0 : pcnt + 1'b1;
            if (slot_end) idx <= idx + 2'd1;
            if (wrap) frame_cnt <= frame_cnt + 1'b1;
            scan_done_q <= wrap;
        end
    end

    // Shadow capture and sticky overflow flag; both may act in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            if (bus.load)     shadow <= bus.bcd_in;
            if (bus.max_tick) ovf    <= 1'b1;
        end
    end

    // Next display values from the current slot and shadow contents
    always_comb begin
        digit       = shadow[{idx, 2'b00} +: 4];
        blank_digit = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2'd3 && shadow[15:12] == 4'd0) blank_digit = 1'b1;
        if (idx == 2'd2 && shadow[15:8]  == 8'd0) blank_digit = 1'b1;
`endif
        seg_n = blank_digit ? 7'b1111111 : decode(digit);
        an_n  = ~(4'b0001 << idx);
        // Overflow blink only gates the anodes; seg/dp keep scanning
        if (ovf && frame_cnt[BLINK_LOG2]) an_n = 4'b1111;
        dp_n  = (idx != 2'd1);
    end

    // Pin-facing output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_n;
            seg_q <= seg_n;
            dp_q  <= dp_n;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.scan_done = scan_done_q;
endmodule

// File: tb/tb_stopwatch_disp_mux.sv
// Self-checking bench for stopwatch_disp_mux: reset/scan vector table,
// hand sequences for mid-slot load, invalid digits and overflow blink,
// then randomized traffic against a cycle-count based reference model.
module tb_stopwatch_disp_mux;
    localparam int R = 4;
    localparam int B = 2;
    localparam int SCAN = 4 * R;

    logic clk = 1'b0;
    logic reset;
    stopwatch_disp_mux_if bus();

    stopwatch_disp_mux #(.REFRESH_DIV(R), .BLINK_LOG2(B)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: edges since reset release, captured digits, overflow
    int          m_c;
    logic [15:0] m_sh;
    logic        m_ovf;

    logic [6:0] dec_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                   7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                                   7'h3F, 7'h3F, 7'h3F, 7'h3F};

    function automatic logic [6:0] m_seg(input logic [15:0] sh, input int i);
        logic [3:0] d;
        d = sh[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 3 && sh[15:12] == 4'd0) return 7'h7F;
        if (i == 2 && sh[15:8] == 8'd0)  return 7'h7F;
`endif
        return dec_tab[d];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (c=%0d)", name, act, exp, m_c);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs
    task automatic step(input logic r, input logic ld, input logic [15:0] b, input logic mt);
        logic [3:0] ea;
        logic [6:0] es;
        logic ed, esd;
        int slot, scan;
        reset = r; bus.load = ld; bus.bcd_in = b; bus.max_tick = mt;
        @(posedge clk);
        if (r) begin
            ea = 4'hF; es = 7'h7F; ed = 1'b1; esd = 1'b0;
            m_c = 0; m_sh = '0; m_ovf = 1'b0;
        end else begin
            slot = (m_c / R) % 4;
            scan = m_c / SCAN;
            ea   = ~(4'b0001 << slot);
            if (m_ovf && ((scan >> B) & 1) == 1) ea = 4'hF;
            es   = m_seg(m_sh, slot);
            ed   = (slot != 1);
            esd  = ((m_c % SCAN) == SCAN - 1);
            if (ld) m_sh = b;
            if (mt) m_ovf = 1'b1;
            m_c++;
        end
        #1;
        chk("model", {3'b0, bus.an, bus.seg, bus.dp, bus.scan_done},
                     {3'b0, ea, es, ed, esd});
    endtask

    typedef struct {
        logic r; logic ld; logic [15:0] b; logic mt;
        logic [3:0] an; logic [6:0] seg; logic dp; logic sd;
    } vec_t;
    vec_t tbl [7];

    logic [6:0] exp_a5f0 [4] = '{7'h40, 7'h3F, 7'h12, 7'h3F};
    int cnt, k, slot, scan;
    logic seen;

    initial begin
        reset = 1'b1; bus.load = 1'b0; bus.bcd_in = '0; bus.max_tick = 1'b0;
        m_c = 0; m_sh = '0; m_ovf = 1'b0;

        tbl[0] = '{1, 0, 16'h0000, 0, 4'hF, 7'h7F, 1, 0};
        tbl[1] = '{1, 0, 16'h0000, 0, 4'hF, 7'h7F, 1, 0};
        tbl[2] = '{0, 1, 16'h1234, 0, 4'hE, 7'h40, 1, 0};
        tbl[3] = '{0, 0, 16'h0000, 0, 4'hE, 7'h19, 1, 0};
        tbl[4] = '{0, 0, 16'h0000, 0, 4'hE, 7'h19, 1, 0};
        tbl[5] = '{0, 0, 16'h0000, 0, 4'hE, 7'h19, 1, 0};
        tbl[6] = '{0, 0, 16'h0000, 0, 4'hD, 7'h30, 0, 0};

        // Reset and first slots after release
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].r, tbl[i].ld, tbl[i].b, tbl[i].mt);
            chk($sformatf("vec%0d", i), {3'b0, bus.an, bus.seg, bus.dp, bus.scan_done},
                {3'b0, tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].sd});
        end

        // scan_done period: two pulses exactly one scan apart, bounded wait
        seen = 1'b0;
        for (int i = 0; i < 3 * SCAN && !seen; i++) begin
            step(0, 0, 16'h0, 0);
            seen = bus.scan_done;
        end
        chk("scan_done_seen", {15'b0, seen}, 16'h1);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 3 * SCAN && !seen; i++) begin
            step(0, 0, 16'h0, 0);
            cnt++;
            seen = bus.scan_done;
        end
        chk("scan_period", 16'(cnt), 16'(SCAN));

        // Mid-slot load while idx=2: new digit on the second edge
        for (int i = 0; i < SCAN && !((m_c / R) % 4 == 2 && m_c % R == 0); i++)
            step(0, 0, 16'h0, 0);
        step(0, 1, 16'h0999, 0);
        chk("midload_seg_old", {9'b0, bus.seg}, 16'h0024);
        chk("midload_an_old", {12'b0, bus.an}, 16'h000B);
        step(0, 0, 16'h0, 0);
        chk("midload_seg_new", {9'b0, bus.seg}, 16'h0010);
        chk("midload_an_new", {12'b0, bus.an}, 16'h000B);

        // Invalid digits with simultaneous overflow, then blink pattern
        step(1, 0, 16'h0, 0);
        step(0, 1, 16'hA5F0, 1);
        for (k = 1; k < 9 * SCAN; k++) begin
            step(0, 0, 16'h0, 0);
            if (k % R == 1) begin
                scan = k / SCAN; slot = (k / R) % 4;
                chk($sformatf("blink_an_s%0d", scan), {12'b0, bus.an},
                    (scan >= 4 && scan <= 7) ? 16'h000F : {12'b0, ~(4'b0001 << slot)});
                chk($sformatf("a5f0_seg_d%0d", slot), {9'b0, bus.seg}, {9'b0, exp_a5f0[slot]});
            end
        end
        // Move into the next blink window, reset there, scan resumes normally
        for (int i = 0; i < 8 * SCAN && !((m_c / SCAN) % 8 >= 4); i++)
            step(0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0);
        chk("blink_window", {12'b0, bus.an}, 16'h000F);
        step(1, 0, 16'h0, 0);
        chk("reset_in_blink_an", {12'b0, bus.an}, 16'h000F);
        step(0, 0, 16'h0, 0);
        chk("resume_an", {12'b0, bus.an}, 16'h000E);
        chk("resume_seg", {9'b0, bus.seg}, 16'h0040);
        while (m_c < 4 * SCAN + 1) step(0, 0, 16'h0, 0);
        chk("ovf_cleared", {12'b0, bus.an}, 16'h000E);

`ifdef LEADING_ZERO_BLANK_EN
        // Leading-zero blanking of digits 3 and 2
        step(1, 0, 16'h0, 0);
        step(0, 1, 16'h0007, 0);
        for (k = 1; k <= SCAN; k++) begin
            step(0, 0, 16'h0, 0);
            if (k % R == 1) begin
                slot = (k / R) % 4;
                chk($sformatf("lzb0007_d%0d", slot), {9'b0, bus.seg},
                    slot == 0 ? 16'h0078 : slot == 1 ? 16'h0040 : 16'h007F);
            end
        end
        step(0, 1, 16'h0107, 0);
        for (k = 0; k < SCAN; k++) begin
            step(0, 0, 16'h0, 0);
            slot = ((m_c - 1) / R) % 4;
            if (slot == 2) chk("lzb0107_d2", {9'b0, bus.seg}, 16'h0079);
            if (slot == 3) chk("lzb0107_d3", {9'b0, bus.seg}, 16'h007F);
        end
`endif

        // Randomized traffic checked by the model each cycle
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 7) == 0,
                 16'($urandom),
                 $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
